// File: rtl/tt_lfsr_scrambler_if.sv
// tt_lfsr_scrambler_if
//   TinyTapeout tile pin bundle for the LFSR scrambler.
//   io_in  [7:0] : {bypass, load, dir, mode, valid, din, rst_n, clk}
//   io_out [7:0] : {state[4:0], frame_end, dout_valid, dout}
//   master drives io_in and observes io_out; slave is the scrambler tile.
interface tt_lfsr_scrambler_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input  io_out);
  modport slave  (input  io_in, output io_out);
endinterface

// File: rtl/tt_lfsr_scrambler.sv
// tt_lfsr_scrambler
//   Serial LFSR scrambler/descrambler for an 8-in/8-out tile. Supports
//   additive and self-synchronising modes, bypass, and an optional frame
//   counter enabled by defining TT_SCRAMBLER_FRAME_EN.
//   Ports (via tt_lfsr_scrambler_if.slave):
//     io_in[0] clk      io_in[1] rst_n (sync, active-low)
//     io_in[2] din      io_in[3] valid   io_in[4] mode (0 add, 1 self-sync)
//     io_in[5] dir      io_in[6] load    io_in[7] bypass
//     io_out[0] dout    io_out[1] dout_valid   io_out[2] frame_end
//     io_out[7:3] state (S[4:0], zero-extended when WIDTH < 5)
//   Priority: reset, then load, then valid, then idle.
module tt_lfsr_scrambler #(
  parameter int              WIDTH     = 5,
  parameter logic [WIDTH-1:0] TAPS      = 5'b10100,
  parameter logic [WIDTH-1:0] SEED      = 5'b00001,
  parameter int              FRAME_LEN = 8
) (
  tt_lfsr_scrambler_if.slave bus
);

  logic clk, rst_n, din, valid, mode, dir, load, bypass;
  assign {bypass, load, dir, mode, valid, din, rst_n, clk} = bus.io_in;

  logic [WIDTH-1:0] s_q, s_d;
  logic             dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             fb, ss_bit;
  logic             frame_end;
  logic [4:0]       st5;

  assign fb     = ^(s_q & TAPS);
  assign ss_bit = din ^ fb;

  always_comb begin
    s_d    = s_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    if (load) begin
      s_d = SEED;                    // a same-cycle valid bit is dropped
    end else if (valid) begin
      vld_d = 1'b1;
      if (bypass) begin
        dout_d = din;
      end else if (!mode) begin
        if (s_q == '0) begin
          // all-zero state never leaves zero; reseed and pass data through
          s_d    = SEED;
          dout_d = din;
        end else begin
          dout_d = din ^ s_q[WIDTH-1];
          s_d    = {s_q[WIDTH-2:0], fb};
        end
      end else if (!dir) begin
        dout_d = ss_bit;
        s_d    = {s_q[WIDTH-2:0], ss_bit};
      end else begin
        // descrambler shifts in the received bit so it resyncs after WIDTH bits
        dout_d = ss_bit;
        s_d    = {s_q[WIDTH-2:0], din};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= SEED;
      dout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

`ifdef TT_SCRAMBLER_FRAME_EN
  localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fe_q, fe_d;

  // counts every accepted bit, bypass included
  always_comb begin
    cnt_d = cnt_q;
    fe_d  = 1'b0;
    if (load) begin
      cnt_d = '0;
    end else if (valid) begin
      if (cnt_q == CW'(FRAME_LEN - 1)) begin
        cnt_d = '0;
        fe_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      fe_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fe_q  <= fe_d;
    end
  end

  assign frame_end = fe_q;
`else
  assign frame_end = 1'b0;
`endif

  generate
    if (WIDTH >= 5) begin : g_st_wide
      assign st5 = s_q[4:0];
    end else begin : g_st_narrow
      assign st5 = {{(5-WIDTH){1'b0}}, s_q};
    end
  endgenerate

  assign bus.io_out = {st5, frame_end, vld_q, dout_q};

endmodule

// File: tb/tb_tt_lfsr_scrambler.sv
// tb_tt_lfsr_scrambler
//   Scoreboard bench: stimulus pushes expected results, monitors pop and
//   compare whenever dout_valid is seen. A second instance descrambles the
//   first one's output for the round-trip check.
module tb_tt_lfsr_scrambler;
  localparam int         FRAME_LEN = 8;
  localparam logic [4:0] SEED      = 5'b00001;
  localparam logic [4:0] SEED2     = 5'b10110;

  logic clk = 1'b0, rst_n = 1'b0, din = 1'b0, valid = 1'b0;
  logic mode = 1'b0, dir = 1'b0, load = 1'b0, bypass = 1'b0;

  tt_lfsr_scrambler_if bus1 ();
  tt_lfsr_scrambler_if bus2 ();

  assign bus1.io_in = {bypass, load, dir, mode, valid, din, rst_n, clk};
  assign bus2.io_in = {1'b0, load, 1'b1, 1'b1, bus1.io_out[1], bus1.io_out[0], rst_n, clk};

  tt_lfsr_scrambler #(.WIDTH(5), .TAPS(5'b10100), .SEED(SEED), .FRAME_LEN(FRAME_LEN))
    u_scr (.bus(bus1));
  tt_lfsr_scrambler #(.WIDTH(5), .TAPS(5'b10100), .SEED(SEED2), .FRAME_LEN(FRAME_LEN))
    u_dsc (.bus(bus2));

  always #5 clk = ~clk;

  logic       o_dout, o_vld, o_fe;
  logic [4:0] o_state;
  assign {o_state, o_fe, o_vld, o_dout} = bus1.io_out;

  typedef struct packed {
    logic       cd;   // check dout
    logic       d;
    logic       cs;   // check state
    logic [4:0] s;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  logic rt_q[$];
  int   total = 0, bad = 0;
  int   rt_idx = 0, rt_checked = 0;
  bit   mon_en = 1'b0;
`ifdef TT_SCRAMBLER_FRAME_EN
  int   tb_cnt = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic clr_cnt();
`ifdef TT_SCRAMBLER_FRAME_EN
    tb_cnt = 0;
`endif
  endtask

  task automatic beat(input logic d, m, dr, bp, cd, ed, cs, input logic [4:0] es);
    exp_t e;
    din = d; mode = m; dir = dr; bypass = bp; valid = 1'b1; load = 1'b0;
    e.cd = cd; e.d = ed; e.cs = cs; e.s = es;
`ifdef TT_SCRAMBLER_FRAME_EN
    e.fe   = (tb_cnt == FRAME_LEN - 1);
    tb_cnt = e.fe ? 0 : tb_cnt + 1;
`else
    e.fe = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk); #1;
    valid = 1'b0; bypass = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0; load = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_load();
    load = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    load = 1'b0;
    clr_cnt();
  endtask

  // scrambler monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (o_vld === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_dout_valid: got 1 want 0");
        end else begin
          e = sb.pop_front();
          if (e.cd) chk("dout", 32'(o_dout), 32'(e.d));
          if (e.cs) chk("state", 32'(o_state), 32'(e.s));
          chk("frame_end", 32'(o_fe), 32'(e.fe));
        end
      end else begin
        chk("idle_frame_end", 32'(o_fe), 32'd0);
      end
    end
  end

  // descrambler monitor: first WIDTH bits are still resynchronising
  always @(negedge clk) begin
    logic b;
    if (mon_en && bus2.io_out[1] === 1'b1 && rt_q.size() > 0) begin
      b = rt_q.pop_front();
      if (rt_idx >= 5) begin
        chk("roundtrip", 32'(bus2.io_out[0]), 32'(b));
        rt_checked++;
      end
      rt_idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(o_dout), 32'd0);
    chk("rst_vld", 32'(o_vld), 32'd0);
    chk("rst_fe", 32'(o_fe), 32'd0);
    chk("rst_state", 32'(o_state), 32'(SEED));
    rst_n = 1'b1;
    mon_en = 1'b1;
    clr_cnt();

    // additive, din=0: dout 0,0,0,0,1
    beat(0, 0, 0, 0, 1, 0, 1, 5'b00010);
    beat(0, 0, 0, 0, 1, 0, 1, 5'b00100);
    beat(0, 0, 0, 0, 1, 0, 1, 5'b01001);
    beat(0, 0, 0, 0, 1, 0, 1, 5'b10010);
    beat(0, 0, 0, 0, 1, 1, 1, 5'b00101);
    for (int i = 0; i < 25; i++) beat(0, 0, 0, 0, 0, 0, 0, 5'b0);
    beat(0, 0, 0, 0, 0, 0, 1, SEED);            // 31st bit: full period
    idle(2);

    // drive S to zero via descramble with din=0, then lockup recovery
    do_load();
    beat(0, 1, 1, 0, 1, 0, 1, 5'b00010);
    beat(0, 1, 1, 0, 1, 0, 1, 5'b00100);
    beat(0, 1, 1, 0, 1, 1, 1, 5'b01000);
    beat(0, 1, 1, 0, 1, 0, 1, 5'b10000);
    beat(0, 1, 1, 0, 1, 1, 1, 5'b00000);
    beat(0, 1, 0, 0, 1, 0, 1, 5'b00000);        // self-sync scramble stays zero
    beat(1, 0, 0, 0, 1, 1, 1, SEED);            // additive recovery

    // bypass 1,0,1 with state frozen, then S retained on next additive bit
    beat(1, 0, 0, 1, 1, 1, 1, SEED);
    beat(0, 0, 0, 1, 1, 0, 1, SEED);
    beat(1, 0, 0, 1, 1, 1, 1, SEED);
    beat(0, 0, 0, 0, 1, 0, 1, 5'b00010);
    idle(1);

    // load and valid together: bit dropped, S reloaded
    load = 1'b1; valid = 1'b1; din = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    chk("prio_vld", 32'(o_vld), 32'd0);
    chk("prio_state", 32'(o_state), 32'(SEED));
    load = 1'b0; valid = 1'b0;
    clr_cnt();
    beat(0, 0, 0, 0, 1, 0, 1, 5'b00010);
    beat(0, 0, 0, 0, 1, 0, 1, 5'b00100);
    beat(0, 0, 0, 0, 1, 0, 1, 5'b01001);

    // reset mid-frame with valid high
    rst_n = 1'b0; valid = 1'b1; din = 1'b1; load = 1'b0;
    @(posedge clk); #1;
    chk("midrst_dout", 32'(o_dout), 32'd0);
    chk("midrst_vld", 32'(o_vld), 32'd0);
    chk("midrst_fe", 32'(o_fe), 32'd0);
    chk("midrst_state", 32'(o_state), 32'(SEED));
    rst_n = 1'b1; valid = 1'b0;
    clr_cnt();
    idle(1);

    // frame: 20 accepted bits, gap after bit 2, bypass on bit 10
    do_load();
    beat(1, 0, 0, 0, 0, 0, 0, 5'b0);
    beat(0, 0, 0, 0, 0, 0, 0, 5'b0);
    idle(2);
    for (int k = 3; k <= 20; k++)
      beat(k[0], 0, 0, (k == 10), 0, 0, 0, 5'b0);
    idle(3);

    // round trip through the descrambler (different seed)
    do_load();
    idle(3);
    for (int i = 0; i < 64; i++) begin
      logic b;
      b = 1'($urandom);
      rt_q.push_back(b);
      beat(b, 1, 0, 0, 0, 0, 0, 5'b0);
    end
    idle(5);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    chk("rt_drain", 32'(rt_q.size()), 32'd0);
    chk("rt_checked", 32'(rt_checked), 32'd59);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
